// File: rtl/uart_rx_os_if.sv
// Signal bundle between the oversampling UART receiver and its host.
// The master side drives the serial line, oversample tick and consume strobe.
interface uart_rx_os_if #(
    parameter int DATA_BITS = 8
);
    logic                 RxD;
    logic                 baud_tick;
    logic                 clr_rda;
    logic [DATA_BITS-1:0] rx_data;
    logic                 RDA;
    logic                 parity_err;
    logic                 framing_err;
    logic                 overrun;
    logic                 busy;
    logic [2:0]           state_dbg;

    // RDA rises with a completed word and stays set until a one-cycle clr_rda;
    // a word completing while RDA is still set (and not consumed that cycle) sets overrun.
    modport master (
        output RxD, baud_tick, clr_rda,
        input  rx_data, RDA, parity_err, framing_err, overrun, busy, state_dbg
    );

    modport slave (
        input  RxD, baud_tick, clr_rda,
        output rx_data, RDA, parity_err, framing_err, overrun, busy, state_dbg
    );
endinterface

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: start-bit midpoint validation, mid-bit sampling,
// configurable data width, parity and stop bits, with sticky RDA/overrun status.
module uart_rx_os #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic          clk,
    input  logic          reset,
    uart_rx_os_if.slave   bus
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HALF_T = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST_T = TW'(OVERSAMPLE - 1);
    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t               r_state, w_state_nx;
    logic [1:0]           r_sync;
    logic [TW-1:0]        r_tcnt, w_tcnt_nx;
    logic [3:0]           r_bcnt, w_bcnt_nx;
    logic [DATA_BITS-1:0] r_shift, w_shift_nx;
    logic                 r_perr_i, w_perr_nx;
    logic                 r_ferr_i, w_ferr_nx;
    logic                 w_done;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rda, r_parity_err, r_framing_err, r_overrun;

    logic w_rx_s, w_mid, w_par;
    assign w_rx_s = r_sync[1];
    assign w_mid  = (r_tcnt == LAST_T);
    assign w_par  = ^{r_shift, w_rx_s};

    always_comb begin
        w_state_nx = r_state;
        w_tcnt_nx  = r_tcnt;
        w_bcnt_nx  = r_bcnt;
        w_shift_nx = r_shift;
        w_perr_nx  = r_perr_i;
        w_ferr_nx  = r_ferr_i;
        w_done     = 1'b0;
        if (bus.baud_tick) begin
            case (r_state)
                S_IDLE: begin
                    if (!w_rx_s) begin
                        w_tcnt_nx  = '0;
                        w_state_nx = S_START;
                    end
                end
                S_START: begin
                    if (r_tcnt == HALF_T) begin
                        // A line back high at mid start bit was only a glitch.
                        if (w_rx_s) begin
                            w_state_nx = S_IDLE;
                        end else begin
                            w_tcnt_nx  = '0;
                            w_bcnt_nx  = '0;
                            w_perr_nx  = 1'b0;
                            w_ferr_nx  = 1'b0;
                            w_state_nx = S_DATA;
                        end
                    end else begin
                        w_tcnt_nx = r_tcnt + 1'b1;
                    end
                end
                S_DATA: begin
                    w_tcnt_nx = r_tcnt + 1'b1;
                    if (w_mid) begin
                        w_shift_nx = {w_rx_s, r_shift[DATA_BITS-1:1]};
                        w_bcnt_nx  = r_bcnt + 1'b1;
                        if (r_bcnt == LAST_DATA) begin
                            w_bcnt_nx  = '0;
                            w_state_nx = (PARITY != 0) ? S_PARITY : S_STOP;
                        end
                    end
                end
                S_PARITY: begin
                    w_tcnt_nx = r_tcnt + 1'b1;
                    if (w_mid) begin
                        w_perr_nx  = (PARITY == 1) ? ~w_par : w_par;
                        w_state_nx = S_STOP;
                    end
                end
                S_STOP: begin
                    w_tcnt_nx = r_tcnt + 1'b1;
                    if (w_mid) begin
                        w_ferr_nx = r_ferr_i | ~w_rx_s;
                        if (r_bcnt == LAST_STOP) begin
                            w_done     = 1'b1;
                            w_state_nx = S_IDLE;
                        end else begin
                            w_bcnt_nx = r_bcnt + 1'b1;
                        end
                    end
                end
                default: w_state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_sync        <= 2'b11;
            r_tcnt        <= '0;
            r_bcnt        <= '0;
            r_shift       <= '0;
            r_perr_i      <= 1'b0;
            r_ferr_i      <= 1'b0;
            r_rx_data     <= '0;
            r_rda         <= 1'b0;
            r_parity_err  <= 1'b0;
            r_framing_err <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_sync   <= {r_sync[0], bus.RxD};
            r_tcnt   <= w_tcnt_nx;
            r_bcnt   <= w_bcnt_nx;
            r_shift  <= w_shift_nx;
            r_perr_i <= w_perr_nx;
            r_ferr_i <= w_ferr_nx;
            // Completion outranks a coincident clr_rda; that clear only consumes the old word.
            if (w_done) begin
                r_rx_data     <= r_shift;
                r_rda         <= 1'b1;
                r_parity_err  <= r_perr_i;
                r_framing_err <= w_ferr_nx;
                r_overrun     <= r_overrun | (r_rda & ~bus.clr_rda);
            end else if (bus.clr_rda) begin
                r_rda     <= 1'b0;
                r_overrun <= 1'b0;
            end
        end
    end

    assign bus.rx_data     = r_rx_data;
    assign bus.RDA         = r_rda;
    assign bus.parity_err  = r_parity_err;
    assign bus.framing_err = r_framing_err;
    assign bus.overrun     = r_overrun;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.state_dbg   = r_state;
endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: an 8N1 instance and an 8E1 instance share clock,
// reset and a 1-in-4 baud tick; bit period is 64 clk.
module tb_uart_rx_os;
    localparam int BIT_CLK = 64;
    localparam logic [2:0] ST_STOP = 3'd4;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    logic [7:0] exp_q[$];

    uart_rx_os_if #(.DATA_BITS(8)) bus_n();
    uart_rx_os_if #(.DATA_BITS(8)) bus_e();

    uart_rx_os #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1)) dut_n (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_n.slave)
    );

    uart_rx_os #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(2), .STOP_BITS(1)) dut_e (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_e.slave)
    );

    // Clock and baud tick
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        bus_n.baud_tick = 1'b0;
        bus_e.baud_tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            bus_n.baud_tick = 1'b1;
            bus_e.baud_tick = 1'b1;
            @(negedge clk);
            bus_n.baud_tick = 1'b0;
            bus_e.baud_tick = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Driver tasks
    task automatic set_line(input int which, input logic v);
        if (which == 0) bus_n.RxD = v;
        else            bus_e.RxD = v;
    endtask

    task automatic send_frame(input int which, input logic [7:0] data,
                              input logic par, input logic stop);
        logic [10:0] bits;
        int n;
        if (which == 0) begin
            bits = {1'b0, stop, data, 1'b0};
            n = 10;
        end else begin
            bits = {stop, par, data, 1'b0};
            n = 11;
        end
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            set_line(which, bits[i]);
            repeat (BIT_CLK - 1) @(negedge clk);
        end
        @(negedge clk);
        set_line(which, 1'b1);
    endtask

    task automatic pulse_clr(input int which);
        @(negedge clk);
        if (which == 0) bus_n.clr_rda = 1'b1;
        else            bus_e.clr_rda = 1'b1;
        @(negedge clk);
        bus_n.clr_rda = 1'b0;
        bus_e.clr_rda = 1'b0;
    endtask

    task automatic wait_rda(input int which);
        int k;
        k = 0;
        while (((which == 0) ? bus_n.RDA : bus_e.RDA) !== 1'b1 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 2000) check("rda_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle_gap();
        repeat (BIT_CLK) @(negedge clk);
    endtask

    // Scoreboard: compare the held word against the oldest expected frame
    task automatic check_frame(input int which, input string tag);
        logic [7:0] exp;
        if (exp_q.size() == 0) begin
            check({tag, "_noexp"}, 32'd0, 32'd1);
        end else begin
            exp = exp_q.pop_front();
            check(tag, (which == 0) ? bus_n.rx_data : bus_e.rx_data, exp);
        end
    endtask

    initial begin
        int k;
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1;
        bus_n.RxD = 1'b1;
        bus_e.RxD = 1'b1;
        bus_n.clr_rda = 1'b0;
        bus_e.clr_rda = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("rst_data",  bus_n.rx_data, 32'h0);
        check("rst_rda",   bus_n.RDA, 32'd0);
        check("rst_perr",  bus_n.parity_err, 32'd0);
        check("rst_ferr",  bus_n.framing_err, 32'd0);
        check("rst_ovr",   bus_n.overrun, 32'd0);
        check("rst_busy",  bus_n.busy, 32'd0);
        idle_gap();

        // 8N1 0x55; busy must already be low when RDA is first seen
        exp_q.push_back(8'h55);
        fork
            send_frame(0, 8'h55, 1'b0, 1'b1);
            begin
                wait_rda(0);
                check("55_busy", bus_n.busy, 32'd0);
            end
        join
        check_frame(0, "55_data");
        check("55_rda",  bus_n.RDA, 32'd1);
        check("55_perr", bus_n.parity_err, 32'd0);
        check("55_ferr", bus_n.framing_err, 32'd0);
        check("55_ovr",  bus_n.overrun, 32'd0);
        pulse_clr(0);
        check("clr_rda", bus_n.RDA, 32'd0);
        idle_gap();

        // False start: 3 ticks low
        @(negedge clk);
        bus_n.RxD = 1'b0;
        repeat (10) @(negedge clk);
        check("fs_busy_hi", bus_n.busy, 32'd1);
        repeat (2) @(negedge clk);
        bus_n.RxD = 1'b1;
        repeat (60) @(negedge clk);
        check("fs_busy_lo", bus_n.busy, 32'd0);
        check("fs_rda",     bus_n.RDA, 32'd0);
        idle_gap();

        exp_q.push_back(8'hC3);
        send_frame(0, 8'hC3, 1'b0, 1'b1);
        check("c3_rda", bus_n.RDA, 32'd1);
        check_frame(0, "c3_data");
        pulse_clr(0);
        idle_gap();

        // Low stop bit, then a clean frame
        exp_q.push_back(8'h3C);
        send_frame(0, 8'h3C, 1'b0, 1'b0);
        check_frame(0, "3c_data");
        check("3c_ferr", bus_n.framing_err, 32'd1);
        check("3c_rda",  bus_n.RDA, 32'd1);
        pulse_clr(0);
        idle_gap();
        exp_q.push_back(8'h81);
        send_frame(0, 8'h81, 1'b0, 1'b1);
        check_frame(0, "81_data");
        check("81_ferr", bus_n.framing_err, 32'd0);
        pulse_clr(0);
        idle_gap();

        // Even parity: 0xA3 has four ones, so the correct parity bit is 0
        exp_q.push_back(8'hA3);
        send_frame(1, 8'hA3, 1'b1, 1'b1);
        check_frame(1, "a3_bad_data");
        check("a3_bad_perr", bus_e.parity_err, 32'd1);
        check("a3_bad_rda",  bus_e.RDA, 32'd1);
        pulse_clr(1);
        idle_gap();
        exp_q.push_back(8'hA3);
        send_frame(1, 8'hA3, 1'b0, 1'b1);
        check_frame(1, "a3_ok_data");
        check("a3_ok_perr", bus_e.parity_err, 32'd0);
        pulse_clr(1);
        idle_gap();

        // Back-to-back without consuming
        send_frame(0, 8'h11, 1'b0, 1'b1);
        send_frame(0, 8'h22, 1'b0, 1'b1);
        check("ovr_data", bus_n.rx_data, 32'h22);
        check("ovr_rda",  bus_n.RDA, 32'd1);
        check("ovr_set",  bus_n.overrun, 32'd1);
        pulse_clr(0);
        check("ovr_clr_rda",  bus_n.RDA, 32'd0);
        check("ovr_clr_ovr",  bus_n.overrun, 32'd0);
        check("ovr_clr_data", bus_n.rx_data, 32'h22);
        idle_gap();

        // Back-to-back with clr_rda on exactly the 0x22 completion cycle
        fork
            begin
                send_frame(0, 8'h11, 1'b0, 1'b1);
                send_frame(0, 8'h22, 1'b0, 1'b1);
            end
            begin
                wait_rda(0);
                check("co_first_data", bus_n.rx_data, 32'h11);
                k = 0;
                do begin
                    @(posedge clk);
                    #1;
                    k++;
                end while (bus_n.state_dbg !== ST_STOP && k < 2000);
                if (k >= 2000) check("stop_timeout", 32'd0, 32'd1);
                // Entered STOP on a tick; the 16th tick after it (64 clk) completes
                repeat (BIT_CLK - 1) @(posedge clk);
                @(negedge clk);
                bus_n.clr_rda = 1'b1;
                @(negedge clk);
                bus_n.clr_rda = 1'b0;
                check("co_rda",  bus_n.RDA, 32'd1);
                check("co_ovr",  bus_n.overrun, 32'd0);
                check("co_data", bus_n.rx_data, 32'h22);
            end
        join
        idle_gap();

        // Reset in the middle of data bit 4 of 0xF0 (RDA still set from 0x22)
        fork
            send_frame(0, 8'hF0, 1'b0, 1'b1);
            begin
                repeat (5 * BIT_CLK + BIT_CLK / 2) @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                check("mr_data", bus_n.rx_data, 32'h0);
                check("mr_rda",  bus_n.RDA, 32'd0);
                check("mr_ovr",  bus_n.overrun, 32'd0);
                check("mr_ferr", bus_n.framing_err, 32'd0);
                check("mr_perr", bus_n.parity_err, 32'd0);
                check("mr_busy", bus_n.busy, 32'd0);
            end
        join
        idle_gap();
        check("mr_no_frame", bus_n.RDA, 32'd0);
        exp_q.push_back(8'h0F);
        send_frame(0, 8'h0F, 1'b0, 1'b1);
        check("0f_rda", bus_n.RDA, 32'd1);
        check_frame(0, "0f_data");
        check("0f_ferr", bus_n.framing_err, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Parametrised, oversampling UART receiver that replaces the fixed 8-bit, bit-rate-clocked receiver in the serial path. It runs entirely on `clk`. It samples the serial line on a shared oversample enable tick and validates the start bit at its midpoint. Data, optional parity and 1 or 2 stop bits are deserialised LSB first, and the block reports framing, parity and overrun errors alongside the held word and the ready flag `RDA`.

## Interface
- `DATA_BITS`, default 8: data bits per frame; legal range 5..9.
- `OVERSAMPLE`, default 16: `baud_tick` pulses per bit period; must be a power of 2 and ≥4.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: 1 or 2.

Ports:
- `clk`  in  1  sole clock; all logic is on its rising edge.
- `reset`  in  1  reset; synchronous and active-high.
- `RxD`  in  1  asynchronous serial line; idles high.
- `baud_tick`  in  1  one-`clk` enable pulse, at OVERSAMPLE × bit rate.
- `clr_rda`  in  1  one-cycle consume strobe; clears `RDA` and `overrun`.
- `rx_data`  out  DATA_BITS  last completed word; held until the next frame completes.
- `RDA`  out  1  received-data-available; sticky.
- `parity_err`  out  1  parity status of the last completed frame; always 0 when PARITY=0.
- `framing_err`  out  1  a stop bit of the last completed frame sampled low.
- `overrun`  out  1  a frame completed while `RDA` was still set; sticky.
- `busy`  out  1  high in every FSM state except IDLE.

## Operation
- **Synchroniser.** `RxD` passes through a 2-flop synchroniser; both flops reset to 1. All decisions use the synchronised value `rx_s`.
- **Counters.** The tick counter `tcnt` is log2(OVERSAMPLE) bits. The bit counter `bcnt` is 4 bits. Both advance only on cycles where `baud_tick`=1.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
- **IDLE:** on `baud_tick` with `rx_s`=0, clear `tcnt` and go to START.
- **START:** on the tick where `tcnt`=OVERSAMPLE/2−1 (start-bit midpoint):
  - If `rx_s`=1, it is a false start: return to IDLE with no flag changes.
  - Otherwise clear `tcnt` and `bcnt` and go to DATA.
- **Mid-bit sampling.** In DATA, PARITY and STOP, sample `rx_s` on the tick where `tcnt`=OVERSAMPLE−1; `tcnt` then wraps to 0. This places every sample at the midpoint of its bit.
- **DATA:** shift the sample into the MSB of the shift register (right shift), so the first received bit ends at bit 0. Increment `bcnt` per sample. After sample number DATA_BITS, go to PARITY if PARITY≠0, else to STOP.
- **PARITY:** compute XOR of the data bits and the parity bit. Odd mode expects 1; even mode expects 0. Store the mismatch internally, then go to STOP.
- **STOP:** sample STOP_BITS stop bits. Any low sample sets the internal framing flag.
- **Frame completion** happens on the cycle of the last stop sample. On that cycle the block registers:
  - `rx_data` ← shift register;
  - `RDA` ← 1;
  - `parity_err` and `framing_err` ← internal flags;
  - `overrun` ← `overrun` | (`RDA` & ~`clr_rda`).
  It then goes to IDLE.
- **Early IDLE.** Entering IDLE at mid stop bit lets back-to-back frames be received with no gap.
- **Break or low stop bit.** The frame completes with `framing_err`=1. IDLE then sees `rx_s`=0 and starts a new frame normally, so a held break yields repeated 0x00 frames with framing errors.
- **`clr_rda`** clears `RDA` and `overrun` on the next edge. It has no effect on `rx_data`, `parity_err` or `framing_err`.

## Timing
- **Reset values:**
  - `rx_data`=0;
  - `RDA`, `parity_err`, `framing_err`, `overrun`, `busy` = 0;
  - state IDLE, counters 0, synchroniser flops 1.
- **Reset mid-frame** aborts the frame with no completion; the reset values apply on the next edge.
- **Input latency:** 2 `clk` from `RxD` to `rx_s`.
- **`busy`** rises 1 `clk` after the start-detect tick.
- **Completion:** `RDA` and all status outputs change together, 1 `clk` after the `baud_tick` that samples the last stop bit. They occur ≈(1 + DATA_BITS + P + STOP_BITS − 0.5) bit periods after the falling start edge, where P=1 if PARITY≠0 and P=0 otherwise.
- **`clr_rda` on the completion cycle:** completion wins. `RDA`=1, and `overrun`=0 because the previous word counts as consumed.
- **`clr_rda` while `RDA`=0:** no effect.
- **`baud_tick` held continuously high** is legal: the block then runs at 1 tick per `clk`.

## Test plan
Common setup, unless a scenario states otherwise: OVERSAMPLE=16, `baud_tick` every 4 `clk`, bit period 64 `clk`.
- 8N1, send 0x55 → `rx_data`=0x55, `RDA`=1, `parity_err`=`framing_err`=`overrun`=0; `busy` low one `clk` after the last stop-bit sample.
- `RxD` low for 3 ticks then high → no `RDA`; `busy` returns to 0 at the midpoint check; next valid frame 0xC3 received correctly.
- PARITY=2 (even), send 0xA3 with parity bit 1 (wrong) → `rx_data`=0xA3, `parity_err`=1. Resend with parity 0 → `parity_err`=0.
- 8N1, send 0x3C with stop bit driven low → `rx_data`=0x3C, `framing_err`=1, `RDA`=1. Then send 0x81 correctly → `framing_err`=0.
- Send 0x11 then 0x22 back-to-back with no `clr_rda` → `rx_data`=0x22, `overrun`=1. Pulse `clr_rda` → `RDA`=0 and `overrun`=0 next `clk`. Repeat with `clr_rda` coincident with the 0x22 completion → `RDA`=1, `overrun`=0.
- Assert `reset` during data bit 4 of 0xF0 → all outputs 0 next `clk`, `busy`=0. Subsequent 0x0F frame → `rx_data`=0x0F.
